// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN front-end window fetch path.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ADV   = 2'd2,
    DONE  = 2'd3
  } win_state_t;

  // Number of window positions along one image dimension.
  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

endpackage

// File: rtl/cnn_win_pos.sv
// Window position tracker: row/col counters and the incrementally updated
// base address of the current window.
module cnn_win_pos
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int AW     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [AW-1:0] base,
  output logic          last
);

  localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H = out_dim(IMG_H, K, STRIDE);

  localparam logic [AW-1:0] COL_STEP = AW'(STRIDE);
  // Jump from the last column of one window row to column 0 of the next.
  localparam logic [AW-1:0] ROW_STEP = AW'(STRIDE * IMG_W - (OUT_W - 1) * STRIDE);
  localparam logic [AW-1:0] COL_END  = AW'(OUT_W - 1);
  localparam logic [AW-1:0] ROW_END  = AW'(OUT_H - 1);

  logic [AW-1:0] row;
  logic [AW-1:0] col;
  logic          col_end;

  assign col_end = (col == COL_END);
  assign last    = col_end && (row == ROW_END);

  // Advance one window position per adv pulse; wrap to (0,0) after the last window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      base <= '0;
    end else if (clr) begin
      row  <= '0;
      col  <= '0;
      base <= '0;
    end else if (adv) begin
      if (last) begin
        row  <= '0;
        col  <= '0;
        base <= '0;
      end else if (col_end) begin
        col  <= '0;
        row  <= row + AW'(1);
        base <= base + ROW_STEP;
      end else begin
        col  <= col + AW'(1);
        base <= base + COL_STEP;
      end
    end
  end

endmodule

// File: rtl/cnn_win_fetch.sv
// Sliding-window fetch engine: reads each KxK window from the pixel RAM in
// row-major tap order as soon as enough of the frame has been written, and
// streams the taps with first/last framing and an end-of-frame pulse.
module cnn_win_fetch
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int DW     = 1,
  parameter int AW     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [AW:0]   wr_cnt,
  input  logic          bsy,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          win_vld,
  output logic [DW-1:0] win_data,
  output logic          win_first,
  output logic          win_last,
  output logic          frame_done
);

  if (K > IMG_W || K > IMG_H) begin : g_bad_k
    $error("cnn_win_fetch: kernel larger than image");
  end
  if (STRIDE < 1) begin : g_bad_stride
    $error("cnn_win_fetch: STRIDE must be at least 1");
  end
  if ((64'd1 << AW) < 64'(IMG_W * IMG_H)) begin : g_bad_aw
    $error("cnn_win_fetch: AW too small for the image");
  end

  localparam int KK       = K * K;
  localparam int TW       = (KK > 1) ? $clog2(KK) : 1;
  localparam int ROFF_I   = (K - 1) * IMG_W + (K - 1);

  localparam logic [TW-1:0] TAP_END   = TW'(KK - 1);
  localparam logic [TW-1:0] TAP_COL_E = TW'(K - 1);
  localparam logic [AW-1:0] ROW_PITCH = AW'(IMG_W);
  localparam logic [AW:0]   READY_OFF = ROFF_I[AW:0];

  win_state_t    state;
  win_state_t    state_nxt;
  logic [TW-1:0] tap_cnt;
  logic [TW-1:0] tap_j;
  logic [AW-1:0] tap_off;
  logic [AW-1:0] base;
  logic          tap_last;
  logic          ready;
  logic          pos_last;
  logic          pos_adv;
  logic          in_fetch;

  assign in_fetch = (state == FETCH);
  assign tap_last = (tap_cnt == TAP_END);
  // Last tap of this window already written to RAM.
  assign ready    = wr_cnt > ({1'b0, base} + READY_OFF);
  assign pos_adv  = (state == ADV) && !clr;
  assign rd_addr  = in_fetch ? (base + tap_off + AW'(tap_j)) : '0;
  assign win_data = rd_data;

  cnn_win_pos #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .STRIDE(STRIDE),
    .AW    (AW)
  ) u_pos (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .adv  (pos_adv),
    .base (base),
    .last (pos_last)
  );

  // Next-state logic; clr overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ready && !bsy) state_nxt = FETCH;
      FETCH:   if (tap_last) state_nxt = ADV;
      ADV:     state_nxt = pos_last ? DONE : IDLE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Tap counter plus incremental in-window row offset and column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt <= '0;
      tap_j   <= '0;
      tap_off <= '0;
    end else if (clr || !in_fetch || tap_last) begin
      tap_cnt <= '0;
      tap_j   <= '0;
      tap_off <= '0;
    end else begin
      tap_cnt <= tap_cnt + TW'(1);
      if (tap_j == TAP_COL_E) begin
        tap_j   <= '0;
        tap_off <= tap_off + ROW_PITCH;
      end else begin
        tap_j <= tap_j + TW'(1);
      end
    end
  end

  // Issue flags delayed one cycle to line up with the registered RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_vld    <= 1'b0;
      win_first  <= 1'b0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_vld    <= !clr && in_fetch;
      win_first  <= !clr && in_fetch && (tap_cnt == '0);
      win_last   <= !clr && in_fetch && tap_last;
      frame_done <= !clr && (state == ADV) && pos_last;
    end
  end

endmodule

// File: tb/tb_cnn_win_fetch.sv
// Bench for cnn_win_fetch: instance A uses the 28x28 K=3 S=1 geometry,
// instance B uses 8x8 K=2 S=2. Both RAMs hold data equal to the address.
module tb_cnn_win_fetch;

  localparam int AW_A = 10;
  localparam int DW_A = 10;
  localparam int AW_B = 6;
  localparam int DW_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n_a, clr_a, bsy_a;
  logic [AW_A:0]   wr_cnt_a;
  logic [AW_A-1:0] rd_addr_a;
  logic [DW_A-1:0] rd_data_a, win_data_a;
  logic            win_vld_a, win_first_a, win_last_a, frame_done_a;

  logic            rst_n_b, clr_b, bsy_b;
  logic [AW_B:0]   wr_cnt_b;
  logic [AW_B-1:0] rd_addr_b;
  logic [DW_B-1:0] rd_data_b, win_data_b;
  logic            win_vld_b, win_first_b, win_last_b, frame_done_b;

  cnn_win_fetch #(.IMG_W(28), .IMG_H(28), .K(3), .STRIDE(1), .DW(DW_A), .AW(AW_A)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .clr(clr_a), .wr_cnt(wr_cnt_a), .bsy(bsy_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .win_vld(win_vld_a), .win_data(win_data_a),
    .win_first(win_first_a), .win_last(win_last_a), .frame_done(frame_done_a));

  cnn_win_fetch #(.IMG_W(8), .IMG_H(8), .K(2), .STRIDE(2), .DW(DW_B), .AW(AW_B)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .clr(clr_b), .wr_cnt(wr_cnt_b), .bsy(bsy_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .win_vld(win_vld_b), .win_data(win_data_b),
    .win_first(win_first_b), .win_last(win_last_b), .frame_done(frame_done_b));

  // Registered-read RAMs whose contents equal the address.
  always_ff @(posedge clk) rd_data_a <= DW_A'(rd_addr_a);
  always_ff @(posedge clk) rd_data_b <= DW_B'(rd_addr_b);

  int checks, errors, cyc;
  int win_idx[2], tap_idx[2], done_cnt[2], last_cyc[2], first_cyc[2];
  int bsy_e[2], wr_e[2];
  bit per_chk[2];
  bit b_run;
  int a0_taps[9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
  int b1_taps[4] = '{2, 3, 10, 11};

  function automatic void geom(input int id, output int w, output int k, output int s);
    if (id == 0) begin w = 28; k = 3; s = 1; end
    else         begin w = 8;  k = 2; s = 2; end
  endfunction

  function automatic int exp_addr(input int id, input int n, input int t);
    int w, k, s, ow;
    geom(id, w, k, s);
    ow = (w - k) / s + 1;
    return (n / ow) * s * w + (n % ow) * s + (t / k) * w + (t % k);
  endfunction

  function automatic int kk_of(input int id);
    int w, k, s;
    geom(id, w, k, s);
    return k * k;
  endfunction

  function automatic int tot_of(input int id);
    int w, k, s;
    geom(id, w, k, s);
    return ((w - k) / s + 1) * ((w - k) / s + 1);
  endfunction

  function automatic void model_reset(input int id);
    win_idx[id]   = 0;
    tap_idx[id]   = 0;
    done_cnt[id]  = 0;
    last_cyc[id]  = -100;
    first_cyc[id] = -1;
  endfunction

  // Compare one sampled cycle of an instance against the window-order model.
  task automatic chk(input int id, input logic vld, input logic first, input logic last,
                     input logic done, input int data, input int bsy_prev, input int wr_prev);
    int kk, tot, ea;
    bit exp_done;
    kk  = kk_of(id);
    tot = tot_of(id);
    if (vld) begin
      checks++;
      assert (win_idx[id] < tot) else begin
        errors++; $error("FAIL inst%0d extra_tap win=%0d got tap beyond frame, expected %0d windows", id, win_idx[id], tot);
      end
      ea = exp_addr(id, win_idx[id], tap_idx[id]);
      checks++;
      assert (data === ea) else begin
        errors++; $error("FAIL inst%0d tap_data win=%0d tap=%0d got %0d expected %0d", id, win_idx[id], tap_idx[id], data, ea);
      end
      checks++;
      assert (first === (tap_idx[id] == 0)) else begin
        errors++; $error("FAIL inst%0d win_first tap=%0d got %b expected %b", id, tap_idx[id], first, tap_idx[id] == 0);
      end
      checks++;
      assert (last === (tap_idx[id] == kk - 1)) else begin
        errors++; $error("FAIL inst%0d win_last tap=%0d got %b expected %b", id, tap_idx[id], last, tap_idx[id] == kk - 1);
      end
      if (id == 0 && win_idx[id] == 0) begin
        checks++;
        assert (data === a0_taps[tap_idx[id]]) else begin
          errors++; $error("FAIL A win0_taps tap=%0d got %0d expected %0d", tap_idx[id], data, a0_taps[tap_idx[id]]);
        end
      end
      if (id == 1 && win_idx[id] == 1) begin
        checks++;
        assert (data === b1_taps[tap_idx[id]]) else begin
          errors++; $error("FAIL B win1_taps tap=%0d got %0d expected %0d", tap_idx[id], data, b1_taps[tap_idx[id]]);
        end
      end
      if (tap_idx[id] == 0) begin
        if (id == 0 && win_idx[id] == 26) begin
          checks++;
          assert (data === 28) else begin errors++; $error("FAIL A win26_base got %0d expected 28", data); end
        end
        if (id == 1 && win_idx[id] == 4) begin
          checks++;
          assert (data === 16) else begin errors++; $error("FAIL B win4_base got %0d expected 16", data); end
        end
        checks++;
        assert (bsy_prev == 0) else begin
          errors++; $error("FAIL inst%0d start_while_busy win=%0d got bsy=%0d expected 0", id, win_idx[id], bsy_prev);
        end
        checks++;
        assert (wr_prev > exp_addr(id, win_idx[id], kk - 1)) else begin
          errors++; $error("FAIL inst%0d start_not_ready win=%0d got wr_cnt=%0d expected >%0d", id, win_idx[id], wr_prev, exp_addr(id, win_idx[id], kk - 1));
        end
        if (per_chk[id] && first_cyc[id] >= 0) begin
          checks++;
          assert (cyc - first_cyc[id] == kk + 2) else begin
            errors++; $error("FAIL inst%0d window_period got %0d expected %0d", id, cyc - first_cyc[id], kk + 2);
          end
        end
        first_cyc[id] = cyc;
      end
      if (tap_idx[id] == kk - 1) begin
        tap_idx[id]  = 0;
        win_idx[id]  = win_idx[id] + 1;
        last_cyc[id] = cyc;
      end else begin
        tap_idx[id] = tap_idx[id] + 1;
      end
    end else begin
      checks++;
      assert (first === 1'b0 && last === 1'b0) else begin
        errors++; $error("FAIL inst%0d flags_without_vld got first=%b last=%b expected 0", id, first, last);
      end
    end
    exp_done = (win_idx[id] == tot) && (cyc == last_cyc[id] + 1);
    checks++;
    assert (done === exp_done) else begin
      errors++; $error("FAIL inst%0d frame_done cyc=%0d got %b expected %b", id, cyc, done, exp_done);
    end
    if (done) done_cnt[id]++;
  endtask

  // One clock: sample after the edge, check both instances, drive B's random traffic.
  task automatic tick();
    int bp0, bp1, wp0, wp1, nb;
    logic ca, cb;
    bp0 = int'(bsy_a); bp1 = int'(bsy_b);
    wp0 = int'(wr_cnt_a); wp1 = int'(wr_cnt_b);
    ca = clr_a; cb = clr_b;
    @(posedge clk);
    #1;
    cyc++;
    if (ca) begin
      checks++;
      assert (win_vld_a === 1'b0 && win_last_a === 1'b0 && frame_done_a === 1'b0) else begin
        errors++; $error("FAIL A clr_flush got vld=%b last=%b done=%b expected 0", win_vld_a, win_last_a, frame_done_a);
      end
      model_reset(0);
    end else begin
      chk(0, win_vld_a, win_first_a, win_last_a, frame_done_a, int'(win_data_a), bsy_e[0], wr_e[0]);
    end
    if (cb) model_reset(1);
    else    chk(1, win_vld_b, win_first_b, win_last_b, frame_done_b, int'(win_data_b), bsy_e[1], wr_e[1]);
    bsy_e[0] = bp0; bsy_e[1] = bp1;
    wr_e[0]  = wp0; wr_e[1]  = wp1;
    if (b_run) begin
      nb = int'(wr_cnt_b) + int'($urandom_range(0, 2));
      if (nb > 64) nb = 64;
      wr_cnt_b = nb[AW_B:0];
      bsy_b    = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    checks++;
    assert (rd_addr_a === '0 && win_vld_a === 1'b0 && win_first_a === 1'b0 &&
            win_last_a === 1'b0 && frame_done_a === 1'b0) else begin
      errors++; $error("FAIL %s got addr=%0d vld=%b first=%b last=%b done=%b expected all 0",
                       tag, rd_addr_a, win_vld_a, win_first_a, win_last_a, frame_done_a);
    end
  endtask

  initial begin
    int n, nw;
    bit seen;
    checks = 0; errors = 0; cyc = 0;
    rst_n_a = 1'b0; rst_n_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    bsy_a = 1'b0; bsy_b = 1'b0; wr_cnt_a = '0; wr_cnt_b = '0;
    model_reset(0); model_reset(1);
    per_chk[0] = 1'b0; per_chk[1] = 1'b0;
    bsy_e[0] = 1; bsy_e[1] = 1; wr_e[0] = 0; wr_e[1] = 0;
    b_run = 1'b0;

    #12;
    chk_outputs_zero("reset_values");
    checks++;
    assert (rd_addr_b === '0 && win_vld_b === 1'b0 && frame_done_b === 1'b0) else begin
      errors++; $error("FAIL B reset_values got addr=%0d vld=%b done=%b expected 0", rd_addr_b, win_vld_b, frame_done_b);
    end
    @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1;

    // Streaming threshold: 58 pixels is one short of window 0.
    wr_cnt_a = 11'd58;
    b_run = 1'b1;
    repeat (20) begin
      tick();
      checks++;
      assert (rd_addr_a === '0 && win_vld_a === 1'b0) else begin
        errors++; $error("FAIL stream_hold got addr=%0d vld=%b expected 0/0", rd_addr_a, win_vld_a);
      end
    end
    wr_cnt_a = 11'd59;
    tick();
    checks++;
    assert (rd_addr_a === '0 && win_vld_a === 1'b0 && win_first_a === 1'b0) else begin
      errors++; $error("FAIL stream_fetch0 got addr=%0d vld=%b first=%b expected 0/0/0", rd_addr_a, win_vld_a, win_first_a);
    end
    tick();
    checks++;
    assert (rd_addr_a === 10'd1 && win_first_a === 1'b1) else begin
      errors++; $error("FAIL stream_first got addr=%0d first=%b expected 1/1", rd_addr_a, win_first_a);
    end

    // Whole frame with the frame fully written and no back-pressure.
    wr_cnt_a = 11'd784;
    per_chk[0] = 1'b1;
    n = 0;
    while (done_cnt[0] == 0 && n < 8000) begin tick(); n++; end
    checks++;
    assert (done_cnt[0] == 1 && win_idx[0] == 676) else begin
      errors++; $error("FAIL full_frame got done=%0d windows=%0d expected 1/676", done_cnt[0], win_idx[0]);
    end
    repeat (20) tick();
    checks++;
    assert (done_cnt[0] == 1) else begin
      errors++; $error("FAIL done_once got %0d expected 1", done_cnt[0]);
    end
    per_chk[0] = 1'b0;

    // Busy in IDLE blocks the start.
    clr_a = 1'b1; bsy_a = 1'b1;
    tick();
    clr_a = 1'b0;
    repeat (20) begin
      tick();
      checks++;
      assert (win_vld_a === 1'b0) else begin errors++; $error("FAIL busy_idle got vld=%b expected 0", win_vld_a); end
    end
    bsy_a = 1'b0;
    n = 0;
    while (tap_idx[0] != 3 && n < 12) begin tick(); n++; end
    bsy_a = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 10) begin tick(); seen = win_last_a; n++; end
    checks++;
    assert (seen) else begin errors++; $error("FAIL busy_midwin_last got no win_last expected win_last"); end
    repeat (30) begin
      tick();
      checks++;
      assert (win_vld_a === 1'b0) else begin errors++; $error("FAIL busy_hold got vld=%b expected 0", win_vld_a); end
    end
    bsy_a = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 6) begin tick(); seen = win_first_a; n++; end
    checks++;
    assert (seen) else begin errors++; $error("FAIL busy_release got no win_first expected win_first"); end
    checks++;
    assert (win_idx[0] == 1) else begin errors++; $error("FAIL busy_release_win got %0d expected 1", win_idx[0]); end

    // clr once tap 4 has been delivered aborts the window.
    n = 0;
    while (tap_idx[0] != 5 && n < 10) begin tick(); n++; end
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 8) begin tick(); seen = win_first_a; n++; end
    checks++;
    assert (seen && int'(win_data_a) === 0) else begin
      errors++; $error("FAIL clr_restart got first=%b data=%0d expected 1/0", seen, win_data_a);
    end

    // Asynchronous reset in the middle of a window.
    tick(); tick();
    #3;
    rst_n_a = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    model_reset(0);
    #1;
    rst_n_a = 1'b1;

    // Random streaming with random back-pressure from window 0.
    wr_cnt_a = '0;
    n = 0;
    while (done_cnt[0] == 0 && n < 30000) begin
      tick();
      nw = int'(wr_cnt_a) + int'($urandom_range(0, 3));
      if (nw > 784) nw = 784;
      wr_cnt_a = nw[AW_A:0];
      bsy_a = ($urandom_range(0, 3) == 0);
      n++;
    end
    checks++;
    assert (done_cnt[0] == 1 && win_idx[0] == 676) else begin
      errors++; $error("FAIL random_frame got done=%0d windows=%0d expected 1/676", done_cnt[0], win_idx[0]);
    end

    checks++;
    assert (done_cnt[1] == 1 && win_idx[1] == 16) else begin
      errors++; $error("FAIL B frame got done=%0d windows=%0d expected 1/16", done_cnt[1], win_idx[1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
